// File: rtl/trigger_scheduler.sv
// Trigger scheduler: delays an accepted trigger pulse, runs a req/ack handshake with the
// sensor controller, locks out new triggers until readout ends, and counts dropped triggers.
module trigger_scheduler #(
  parameter int DELAY_WIDTH = 28,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_trigger_en,
  input  logic                   i_trigger_pulse,
  input  logic [DELAY_WIDTH-1:0] iv_trigger_delay,
  input  logic                   i_trigger_ack,
  input  logic                   i_sensor_busy,
  input  logic                   i_drop_cnt_clr,
  output logic                   o_trigger_req,
  output logic                   o_busy,
  output logic [CNT_WIDTH-1:0]   ov_drop_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic [DELAY_WIDTH-1:0] DLY_ZERO = '0;
  localparam logic [DELAY_WIDTH-1:0] DLY_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [DELAY_WIDTH-1:0] dly_q, dly_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic                   trig;

  assign trig = i_trigger_en & i_trigger_pulse;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          if (iv_trigger_delay == DLY_ZERO) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DELAY;
            dly_d   = iv_trigger_delay;
          end
        end
      end
      ST_DELAY: begin
        // Disabling trigger mode cancels a pending trigger before any request is made.
        if (!i_trigger_en) begin
          state_d = ST_IDLE;
        end else begin
          dly_d = dly_q - DLY_ONE;
          if (dly_q == DLY_ONE) state_d = ST_REQ;
        end
      end
      ST_REQ:  if (i_trigger_ack)  state_d = ST_WAIT;
      ST_WAIT: if (!i_sensor_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (i_drop_cnt_clr) begin
      drop_d = '0;
    end else if (trig && (state_q != ST_IDLE)) begin
      drop_d = sat_inc(drop_q);
    end

    // Outputs are registered copies of the next state so they align with state_q.
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      drop_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign o_trigger_req = req_q;
  assign o_busy        = busy_q;
  assign ov_drop_cnt   = drop_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Bench for trigger_scheduler: transaction-level stimulus with a timeline reference model
// feeding a per-cycle expectation queue that a negedge monitor drains.
module tb_trigger_scheduler;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, pulse, ack, sbusy, clr;
  logic [DW-1:0] dly;
  logic          req, obusy;
  logic [CW-1:0] cnt;

  trigger_scheduler #(.DELAY_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_trigger_en     (en),
    .i_trigger_pulse  (pulse),
    .iv_trigger_delay (dly),
    .i_trigger_ack    (ack),
    .i_sensor_busy    (sbusy),
    .i_drop_cnt_clr   (clr),
    .o_trigger_req    (req),
    .o_busy           (obusy),
    .ov_drop_cnt      (cnt)
  );

  typedef struct {
    int            cyc;
    logic          req;
    logic          busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv, input int c);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, c, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against the expectation tagged for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_expectation cycle=%0d actual=%0d expected=%0d", cyc, cyc, mon_e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk("o_trigger_req", {31'b0, req},   {31'b0, mon_e.req},  cyc);
      chk("o_busy",        {31'b0, obusy}, {31'b0, mon_e.busy}, cyc);
      chk("ov_drop_cnt",   {{(32-CW){1'b0}}, cnt}, {{(32-CW){1'b0}}, mon_e.cnt}, cyc);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in the following cycle.
  task automatic step(input bit r, input bit e, input bit p, input bit ak, input bit bz,
                      input bit c, input logic [DW-1:0] dv,
                      input bit xreq, input bit xbusy, input bit drop);
    exp_t x;
    reset = r; en = e; pulse = p; ack = ak; sbusy = bz; clr = c; dly = dv;
    if (r || c) model_cnt = 0;
    else if (drop && model_cnt < CNT_MAX) model_cnt = model_cnt + 1;
    x.cyc  = cyc + 1;
    x.req  = r ? 1'b0 : xreq;
    x.busy = r ? 1'b0 : xbusy;
    x.cnt  = model_cnt[CW-1:0];
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit e, p;
    logic [DW-1:0] dv;
    for (int k = 0; k < n; k++) begin
      e  = ($urandom % 2 == 1);
      p  = e ? 1'b0 : ($urandom % 2 == 1);
      dv = DW'($urandom);
      step(1'b0, e, p, ($urandom % 2 == 1), ($urandom % 2 == 1), ($urandom % 4 == 0),
           dv, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One trigger accepted at k=0. Timeline: request from d+1 through ack cycle a,
  // sensor busy through a+busy_len, last non-idle cycle b. Abort or reset cut it short.
  task automatic run_txn(input int d, input int abort_at, input int ack_lat, input int busy_len,
                         input int rst_at, input int noise, input int clr_at);
    int a, b, last;
    bit r, e, p, ak, bz, c, drop, xreq, xbusy;
    logic [DW-1:0] dv;
    a = d + 1 + ack_lat;
    b = a + 1 + busy_len;
    last = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at : b);
    for (int k = 0; k <= last; k++) begin
      r = (rst_at > 0) && (k == rst_at);
      if (k == 0) e = 1'b1;
      else if (abort_at > 0 && k == abort_at) e = 1'b0;
      else if (k <= d) e = 1'b1;
      else e = (noise > 0) ? ($urandom % 4 != 0) : 1'b1;
      p = (k == 0) ? 1'b1 : ((noise > 0) && ($urandom % 3 == 0));
      c = (noise == 2) && ($urandom % 6 == 0);
      if (clr_at > 0 && k == clr_at) begin
        p = 1'b1; e = 1'b1; c = 1'b1;
      end
      dv = (k == 0) ? d[DW-1:0] : DW'($urandom);
      ak = (k == a) || ((noise > 0) && (k <= d || k > a) && ($urandom % 2 == 0));
      bz = (k >= a && k <= a + busy_len) ? 1'b1 : ((k < a) && (noise > 0) && ($urandom % 2 == 0));
      drop  = (k >= 1) && e && p;
      xbusy = (k + 1 <= last);
      xreq  = (abort_at == 0) && (k + 1 >= d + 1) && (k + 1 <= a);
      step(r, e, p, ak, bz, c, dv, xreq, xbusy, drop);
    end
  endtask

  initial begin
    int d, ab, al, bl, rs, b;
    reset = 1'b1; en = 1'b0; pulse = 1'b0; ack = 1'b0; sbusy = 1'b0; clr = 1'b0; dly = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(2);
    run_txn(0, 0, 2, 0, 0, 0, 0);    // zero delay, ack two cycles after request
    idle(1);
    run_txn(5, 0, 1, 2, 0, 1, 0);    // delay value changes in flight
    idle(1);
    run_txn(10, 4, 1, 1, 0, 0, 0);   // abort during delay
    idle(1);
    run_txn(2, 0, 2, 3, 0, 1, 0);    // drops during delay/req/wait
    run_txn(3, 0, 1, 1, 0, 1, 5);    // clear and drop in the same cycle
    idle(1);
    run_txn(1, 0, 2, 40, 0, 1, 0);   // drop counter saturation
    run_txn(2, 0, 5, 0, 4, 0, 0);    // reset while requesting
    run_txn(0, 0, 0, 0, 0, 0, 0);
    run_txn(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      d  = $urandom % 7;
      ab = (d > 0 && $urandom % 5 == 0) ? 1 + int'($urandom % d) : 0;
      al = $urandom % 4;
      bl = $urandom % 4;
      b  = d + 2 + al + bl;
      rs = (ab == 0 && $urandom % 8 == 0) ? 1 + int'($urandom % b) : 0;
      run_txn(d, ab, al, bl, rs, 1 + int'($urandom % 2), 0);
      idle($urandom % 3);
    end
    idle(3);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
